// File: rtl/sar_pkg.sv
// Shared types, defaults and helpers for the successive-approximation search controller.
package sar_pkg;

    localparam int unsigned SAR_WIDTH  = 4;
    localparam int unsigned SAR_SETTLE = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECIDE = 2'd2,
        ST_DONE   = 2'd3
    } sar_state_e;

    typedef struct packed {
        logic equal;
        logic greater;
        logic lesser;
    } sar_flags_t;

    // A legal comparator answer has exactly one flag raised.
    function automatic logic onehot3(input sar_flags_t f);
        return $countones(f) == 1;
    endfunction

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sar_settle_timer.sv
// Loadable down-counter that marks the last settle cycle after a trial update.
module sar_settle_timer
    import sar_pkg::*;
#(
    parameter int unsigned SETTLE = SAR_SETTLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_last_c
);

    localparam int unsigned CW = clog2_min1(SETTLE + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(SETTLE);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // High while the count is on its final step towards zero.
    assign o_last_c = (r_cnt <= CW'(1));

endmodule

// File: rtl/sar_search_ctrl.sv
// Binary-searches a comparator target MSB-first by driving trial codes and reading back the flags.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH  = SAR_WIDTH,
    parameter int unsigned SETTLE = SAR_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_equal,
    input  logic             cmp_greater,
    input  logic             cmp_lesser,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err
);

    localparam int unsigned     BW        = clog2_min1(WIDTH);
    localparam logic [BW-1:0]   MSB_IDX   = BW'(WIDTH - 1);
    localparam sar_state_e      ST_TRIAL  = (SETTLE == 0) ? ST_DECIDE : ST_SETTLE;

    sar_state_e       r_state;
    sar_state_e       w_state_nxt;
    logic [BW-1:0]    r_bit;
    logic [BW-1:0]    w_bit_nxt;
    logic [WIDTH-1:0] r_trial;
    logic [WIDTH-1:0] w_trial_nxt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_exact;
    logic             w_exact_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_load;
    logic             w_settle_last;
    logic             w_flags_ok;
    logic             w_finish;
    sar_flags_t       w_flags;
    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_cand;

    assign w_flags    = {cmp_equal, cmp_greater, cmp_lesser};
    assign w_flags_ok = onehot3(w_flags);
    assign w_finish   = !w_flags_ok || w_flags.equal || (r_bit == '0);
    assign w_bit_mask = WIDTH'(1) << r_bit;
    // Trial too high clears the bit under test, otherwise it is kept.
    assign w_cand     = w_flags.greater ? (r_trial & ~w_bit_mask) : r_trial;

    sar_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_dec    (r_state == ST_SETTLE),
        .o_last_c (w_settle_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_TRIAL;
            ST_SETTLE: if (w_settle_last) w_state_nxt = ST_DECIDE;
            ST_DECIDE: w_state_nxt = w_finish ? ST_DONE : ST_TRIAL;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_bit_nxt    = r_bit;
        w_trial_nxt  = r_trial;
        w_result_nxt = r_result;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_exact_nxt  = r_exact;
        w_err_nxt    = r_err;
        w_load       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_busy_nxt   = 1'b1;
                    w_result_nxt = '0;
                    w_exact_nxt  = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_bit_nxt    = MSB_IDX;
                    w_trial_nxt  = WIDTH'(1) << MSB_IDX;
                    w_load       = 1'b1;
                end
            end
            ST_DECIDE: begin
                if (w_finish) begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                    if (!w_flags_ok) begin
                        w_err_nxt    = 1'b1;
                        w_result_nxt = '0;
                    end else if (w_flags.equal) begin
                        w_result_nxt = r_trial;
                        w_exact_nxt  = 1'b1;
                    end else begin
                        w_result_nxt = w_cand;
                    end
                end else begin
                    w_bit_nxt   = r_bit - BW'(1);
                    w_trial_nxt = w_cand | (w_bit_mask >> 1);
                    w_load      = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit    <= '0;
            r_trial  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_exact  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_bit    <= w_bit_nxt;
            r_trial  <= w_trial_nxt;
            r_result <= w_result_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_exact  <= w_exact_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign trial  = r_trial;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign exact  = r_exact;
    assign err    = r_err;

endmodule
